// File: rtl/mul_arbiter_pkg.sv
// Shared types and helpers for the multiplier arbiter.
// FSM state encoding and index-width function.
package mul_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_arbiter_rr_picker.sv
// Round-robin picker: first asserted request after 'last',
// wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_last,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_valid
);

    int w_pos;

    // Scan farthest offset first so the nearest one overwrites.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = int'(i_last) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (i_req[w_pos[IDX_WIDTH-1:0]]) begin
                o_idx   = w_pos[IDX_WIDTH-1:0];
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one handshake multiplier among NUM_REQ requesters with
// round-robin grant, operand latch, watchdog and one-cycle ack.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter  int C_WIDTH   = 32,
    parameter  int NUM_REQ   = 4,
    parameter  int TIMEOUT   = 256,
    localparam int IDX_WIDTH = clog2(NUM_REQ)
) (
    input  logic                       ctl_clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*C_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*C_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]         req_signed,
    output logic [NUM_REQ-1:0]         ack,
    output logic [C_WIDTH-1:0]         resp_y,
    output logic                       resp_err,
    output logic                       busy,
    output logic [IDX_WIDTH-1:0]       grant_idx,
    output logic [C_WIDTH-1:0]         mul_a,
    output logic [C_WIDTH-1:0]         mul_b,
    output logic                       mul_signed,
    output logic                       mul_trigger,
    input  logic                       mul_ready,
    input  logic                       mul_done,
    input  logic [C_WIDTH-1:0]         mul_y
);

    state_t                r_state;
    state_t                w_next;
    logic [IDX_WIDTH-1:0]  r_last;
    logic [31:0]           r_wdog;
    logic [IDX_WIDTH-1:0]  w_win;
    logic                  w_valid;
    logic                  w_tmo;

    rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_idx   (w_win),
        .o_valid (w_valid)
    );

    assign w_tmo = (TIMEOUT != 0) && (r_wdog == 32'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (mul_ready && w_valid) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (mul_done || w_tmo) w_next = ST_RESP;
            // Level-style done must drop before re-arbitrating.
            ST_RESP:  w_next = (!mul_done && mul_ready) ? ST_IDLE : ST_HOLD;
            ST_HOLD:  if (!mul_done && mul_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= IDX_WIDTH'(NUM_REQ - 1);
            r_wdog      <= '0;
            ack         <= '0;
            resp_y      <= '0;
            resp_err    <= 1'b0;
            busy        <= 1'b0;
            grant_idx   <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_signed  <= 1'b0;
            mul_trigger <= 1'b0;
        end else begin
            r_state     <= w_next;
            busy        <= (w_next != ST_IDLE);
            mul_trigger <= (w_next == ST_ISSUE);
            ack         <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_ISSUE) begin
                        mul_a      <= req_a[int'(w_win)*C_WIDTH +: C_WIDTH];
                        mul_b      <= req_b[int'(w_win)*C_WIDTH +: C_WIDTH];
                        mul_signed <= req_signed[w_win];
                        grant_idx  <= w_win;
                    end
                end
                ST_ISSUE: r_wdog <= '0;
                ST_WAIT: begin
                    r_wdog <= r_wdog + 32'd1;
                    if (mul_done) begin
                        resp_y   <= mul_y;
                        resp_err <= 1'b0;
                        ack      <= NUM_REQ'(1) << grant_idx;
                    end else if (w_tmo) begin
                        resp_y   <= '0;
                        resp_err <= 1'b1;
                        ack      <= NUM_REQ'(1) << grant_idx;
                    end
                end
                ST_RESP: begin
                    r_last   <= grant_idx;
                    resp_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomised bench for mul_arbiter with a stub multiplier and a
// round-robin reference model over pending-request sets.
module tb_mul_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;

    logic            ctl_clk = 1'b0;
    logic            reset   = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] req_a = '0;
    logic [NR*W-1:0] req_b = '0;
    logic [NR-1:0]   req_signed = '0;
    logic [NR-1:0]   ack;
    logic [W-1:0]    resp_y;
    logic            resp_err;
    logic            busy;
    logic [1:0]      grant_idx;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic            mul_signed;
    logic            mul_trigger;
    logic            mul_ready;
    logic            mul_done;
    logic [W-1:0]    mul_y;

    mul_arbiter #(
        .C_WIDTH (W),
        .NUM_REQ (NR),
        .TIMEOUT (16)
    ) dut (
        .ctl_clk     (ctl_clk),
        .reset       (reset),
        .req         (req),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_signed  (req_signed),
        .ack         (ack),
        .resp_y      (resp_y),
        .resp_err    (resp_err),
        .busy        (busy),
        .grant_idx   (grant_idx),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_signed  (mul_signed),
        .mul_trigger (mul_trigger),
        .mul_ready   (mul_ready),
        .mul_done    (mul_done),
        .mul_y       (mul_y)
    );

    always #5 ctl_clk = ~ctl_clk;

    // Fixed-point multiply, 8 fractional bits, truncated to 32 bits.
    function automatic logic [31:0] fx(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic s);
        logic [63:0] ea, eb, p;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return p[39:8];
    endfunction

    // Stub multiplier behaviour knobs.
    int   st_lat  = 3;
    int   st_dlen = 1;
    int   st_gap  = 0;
    bit   st_hang = 1'b0;
    int   ph;
    int   cnt;
    logic [31:0] prod;

    always @(posedge ctl_clk) begin
        if (reset) begin
            ph <= 0; cnt <= 0;
            mul_ready <= 1'b1; mul_done <= 1'b0; mul_y <= '0;
        end else if (mul_trigger) begin
            prod <= fx(mul_a, mul_b, mul_signed);
            cnt  <= st_lat; ph <= 1; mul_done <= 1'b0;
            if (!st_hang) mul_ready <= 1'b0;
        end else begin
            case (ph)
                1: if (!st_hang) begin
                    if (cnt <= 1) begin
                        mul_done <= 1'b1; mul_y <= prod;
                        cnt <= st_dlen; ph <= 2;
                    end else cnt <= cnt - 1;
                end
                2: if (cnt <= 1) begin
                    mul_done <= 1'b0; mul_y <= $urandom;
                    if (st_gap == 0) begin
                        mul_ready <= 1'b1; ph <= 0;
                    end else begin
                        cnt <= st_gap; ph <= 3;
                    end
                end else cnt <= cnt - 1;
                3: if (cnt <= 1) begin
                    mul_ready <= 1'b1; ph <= 0;
                end else cnt <= cnt - 1;
                default: ;
            endcase
        end
    end

    // Event monitor: cycle stamps and counts only, no checking.
    int cyc = 0, trig_cnt = 0, trig_cyc = 0, done_cyc = 0;
    int ack_cnt = 0, ack_cyc = 0, bad_trig = 0;
    bit done_seen = 1'b0, prev_ready = 1'b1;

    always @(negedge ctl_clk) begin
        cyc++;
        if (mul_trigger) begin
            trig_cnt++; trig_cyc = cyc; done_seen = 1'b0;
            if (!prev_ready) bad_trig++;
        end
        if (mul_done && !done_seen) begin
            done_cyc = cyc; done_seen = 1'b1;
        end
        if (|ack) begin
            ack_cnt++; ack_cyc = cyc;
        end
        prev_ready = mul_ready;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    int checks = 0;
    int errors = 0;
    int m_last = NR - 1;
    logic [31:0] op_a [NR];
    logic [31:0] op_b [NR];
    logic        op_s [NR];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge ctl_clk);
        #1;
    endtask

    task automatic set_ops();
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
            req_signed[i]   = op_s[i];
        end
    endtask

    function automatic int model_next(input logic [NR-1:0] pend);
        for (int k = 1; k <= NR; k++) begin
            if (pend[(m_last + k) % NR]) return (m_last + k) % NR;
        end
        return 0;
    endfunction

    task automatic run_batch(input logic [NR-1:0] mask, input bit hold,
                             input int ngr, input bit exp_err);
        int guard, got, t0, e;
        logic [NR-1:0] pend;
        guard = 0; got = 0; t0 = trig_cnt; pend = mask;
        set_ops();
        req = req | mask;
        while (((!hold && pend != 0) || (hold && got < ngr))
               && guard < 3000) begin
            tick();
            guard++;
            if (|ack) begin
                e = model_next(pend);
                chk("ack_grant", 64'(ack), 64'(1 << e));
                chk("grant_idx", 64'(grant_idx), 64'(e));
                chk("busy_resp", 64'(busy), 64'(1));
                if (exp_err) begin
                    chk("err_y", 64'(resp_y), 64'(0));
                    chk("err_flag", 64'(resp_err), 64'(1));
                    chk("wdog_cycles", 64'(ack_cyc - trig_cyc), 64'(17));
                end else begin
                    chk("resp_y", 64'(resp_y),
                        64'(fx(op_a[e], op_b[e], op_s[e])));
                    chk("resp_err", 64'(resp_err), 64'(0));
                    chk("done_to_ack", 64'(ack_cyc - done_cyc), 64'(1));
                end
                m_last = e;
                got++;
                if (!hold) begin
                    pend[e] = 1'b0;
                    req[e]  = 1'b0;
                end
            end
        end
        if (hold) req = req & ~mask;
        chk("batch_grants", 64'(got),
            64'(hold ? ngr : $countones(mask)));
        chk("trig_per_grant", 64'(trig_cnt - t0), 64'(got));
    endtask

    initial begin
        int a0, g;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_s[i] = 1'b0;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_trig", 64'(mul_trigger), 64'(0));
        chk("rst_grant", 64'(grant_idx), 64'(0));
        chk("rst_y", 64'(resp_y), 64'(0));
        chk("rst_mula", 64'(mul_a), 64'(0));

        // Single unsigned request: 2.0 * 3.0.
        op_a[0] = 32'h0000_0200; op_b[0] = 32'h0000_0300; op_s[0] = 1'b0;
        run_batch(4'b0001, 1'b0, 0, 1'b0);
        chk("t1_y_held", 64'(resp_y), 64'(32'h0000_0600));

        // Signed: -2.0 * 3.0.
        op_a[2] = 32'hFFFF_FE00; op_b[2] = 32'h0000_0300; op_s[2] = 1'b1;
        run_batch(4'b0100, 1'b0, 0, 1'b0);
        chk("t2_y_held", 64'(resp_y), 64'(32'hFFFF_FA00));

        // Continuous requests, then drop-after-ack.
        for (int i = 0; i < NR; i++) begin
            op_a[i] = $urandom; op_b[i] = $urandom; op_s[i] = 1'($urandom);
        end
        run_batch(4'b1111, 1'b1, 5, 1'b0);
        tick(); tick();
        run_batch(4'b1111, 1'b0, 0, 1'b0);

        // Watchdog against a hung multiplier, then normal recovery.
        st_hang = 1'b1;
        op_a[3] = 32'h0000_0100; op_b[3] = 32'h0000_0500; op_s[3] = 1'b0;
        run_batch(4'b1000, 1'b0, 0, 1'b1);
        st_hang = 1'b0;
        run_batch(4'b1000, 1'b0, 0, 1'b0);

        // Level done for 5 cycles, ready low 3 more.
        st_lat = 2; st_dlen = 5; st_gap = 3;
        a0 = ack_cnt;
        run_batch(4'b0011, 1'b0, 0, 1'b0);
        chk("level_one_ack_each", 64'(ack_cnt - a0), 64'(2));
        st_lat = 3; st_dlen = 1; st_gap = 0;

        // Reset while in WAIT.
        st_lat = 12;
        op_a[1] = 32'h0000_0180; op_b[1] = 32'h0000_0400; op_s[1] = 1'b0;
        set_ops();
        req[1] = 1'b1;
        g = 0;
        while (!mul_trigger && g < 50) begin tick(); g++; end
        chk("rst_trig_seen", 64'(mul_trigger), 64'(1));
        repeat (3) tick();
        a0 = ack_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy", 64'(busy), 64'(0));
        chk("mid_ack", 64'(ack), 64'(0));
        chk("mid_trig", 64'(mul_trigger), 64'(0));
        chk("mid_ops", 64'({mul_a, mul_b} != 0), 64'(0));
        chk("mid_sign", 64'(mul_signed), 64'(0));
        chk("mid_grant", 64'(grant_idx), 64'(0));
        chk("mid_y", 64'(resp_y), 64'(0));
        chk("mid_err", 64'(resp_err), 64'(0));
        m_last = NR - 1;
        st_lat = 4;
        run_batch(4'b0010, 1'b0, 0, 1'b0);
        chk("rst_no_stale_ack", 64'(ack_cnt - a0), 64'(1));

        // Randomised batches.
        for (int it = 0; it < 24; it++) begin
            st_lat  = $urandom_range(1, 10);
            st_dlen = $urandom_range(1, 4);
            st_gap  = $urandom_range(0, 3);
            for (int i = 0; i < NR; i++) begin
                op_a[i] = $urandom; op_b[i] = $urandom;
                op_s[i] = 1'($urandom);
            end
            if (it % 6 == 5) run_batch(4'b1111, 1'b1, 6, 1'b0);
            else run_batch(4'($urandom_range(1, 15)), 1'b0, 0, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        chk("trig_needs_ready", 64'(bad_trig), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
